// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - control and result signals of the PWM capture stage
interface pwm_capture_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             pwm_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             meas_valid;
    logic             timeout;
    logic             stuck_level;

    modport master (
        output en, pwm_in,
        input  high_cnt, period_cnt, meas_valid, timeout, stuck_level
    );

    modport slave (
        input  en, pwm_in,
        output high_cnt, period_cnt, meas_valid, timeout, stuck_level
    );
endinterface

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures PWM high time and period with stuck-line timeout
module pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    pwm_capture_if.slave bus
);
    localparam logic [CNT_W-1:0] MAXC = '1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_MEAS = 2'd2;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   p;
    logic                   rise;

    logic [1:0]       state;
    logic [CNT_W-1:0] hi_acc;
    logic [CNT_W-1:0] per_acc;
    logic [CNT_W-1:0] wait_cnt;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~p;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            p      <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
            p      <= s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            hi_acc          <= '0;
            per_acc         <= '0;
            wait_cnt        <= '0;
            bus.high_cnt    <= '0;
            bus.period_cnt  <= '0;
            bus.meas_valid  <= 1'b0;
            bus.timeout     <= 1'b0;
            bus.stuck_level <= 1'b0;
        end else begin
            bus.meas_valid <= 1'b0;
            if (!bus.en) begin
                state       <= ST_IDLE;
                hi_acc      <= '0;
                per_acc     <= '0;
                wait_cnt    <= '0;
                bus.timeout <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state    <= ST_ARM;
                        wait_cnt <= '0;
                    end
                    ST_ARM: begin
                        if (rise) begin
                            hi_acc   <= 1;
                            per_acc  <= 1;
                            wait_cnt <= '0;
                            state    <= ST_MEAS;
                        end else if (wait_cnt == MAXC) begin
                            // Capture the stuck level only once per timeout event.
                            if (!bus.timeout) begin
                                bus.timeout     <= 1'b1;
                                bus.stuck_level <= s;
                            end
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    ST_MEAS: begin
                        if (rise) begin
                            bus.high_cnt   <= hi_acc;
                            bus.period_cnt <= per_acc;
                            bus.meas_valid <= 1'b1;
                            bus.timeout    <= 1'b0;
                            hi_acc         <= 1;
                            per_acc        <= 1;
                        end else if (per_acc == MAXC) begin
                            bus.timeout     <= 1'b1;
                            bus.stuck_level <= s;
                            hi_acc          <= '0;
                            per_acc         <= '0;
                            wait_cnt        <= '0;
                            state           <= ST_ARM;
                        end else begin
                            per_acc <= per_acc + 1'b1;
                            if (s && hi_acc != MAXC) begin
                                hi_acc <= hi_acc + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;
    localparam int CNT_W = 8;
    localparam int SYNC  = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pwm_capture_if #(.CNT_W(CNT_W)) bus ();

    pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    int   n_strobe = 0;
    int   b2b      = 0;
    logic prev_v   = 1'b0;
    int   last_hi  = 0;
    int   last_per = 0;
    time  t_prev   = 0;
    time  t_last   = 0;
    int   q_hi[$];
    int   q_per[$];

    always @(negedge clk) begin
        if (bus.meas_valid === 1'b1) begin
            n_strobe++;
            last_hi  = int'(bus.high_cnt);
            last_per = int'(bus.period_cnt);
            t_prev   = t_last;
            t_last   = $time;
            q_hi.push_back(last_hi);
            q_per.push_back(last_per);
            if (prev_v) b2b++;
        end
        prev_v = bus.meas_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wave(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            bus.pwm_in = 1'b1;
            tick(hi);
            bus.pwm_in = 1'b0;
            tick(lo);
        end
    endtask

    int n0;
    int lat;

    initial begin
        rst        = 1'b1;
        bus.en     = 1'b0;
        bus.pwm_in = 1'b0;
        tick(3);
        check("rst_high_cnt",   bus.high_cnt,    0);
        check("rst_period_cnt", bus.period_cnt,  0);
        check("rst_valid",      bus.meas_valid,  0);
        check("rst_timeout",    bus.timeout,     0);
        check("rst_stuck",      bus.stuck_level, 0);

        // 3 high / 7 low: first strobe needs two rises
        rst    = 1'b0;
        bus.en = 1'b1;
        tick(3);
        wave(3, 7, 5);
        check("p37_count",  n_strobe, 4);
        check("p37_high",   last_hi,  3);
        check("p37_period", last_per, 10);
        check("p37_gap",    int'((t_last - t_prev) / 10), 10);

        // duty sweep on a 101-cycle period
        q_hi.delete();
        q_per.delete();
        for (int ton = 0; ton < 100; ton += 5) wave(ton + 1, 100 - ton, 1);
        bus.pwm_in = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (bus.meas_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("sweep_latency", lat, SYNC + 1);
        tick(2);
        bus.pwm_in = 1'b0;
        tick(6);
        check("sweep_count", q_hi.size(), 21);
        if (q_hi.size() == 21) begin
            check("sweep_first_high",   q_hi[0],  3);
            check("sweep_first_period", q_per[0], 10);
            for (int i = 1; i <= 20; i++) begin
                check($sformatf("sweep_high_%0d", i),   q_hi[i],  (i - 1) * 5 + 1);
                check($sformatf("sweep_period_%0d", i), q_per[i], 101);
            end
        end

        // minimum period
        n0 = n_strobe;
        wave(1, 1, 10);
        tick(4);
        check("min_count",  n_strobe - n0, 10);
        check("min_high",   last_hi,  1);
        check("min_period", last_per, 2);
        check("min_no_b2b", b2b,      0);

        // en dropped mid-period
        wave(4, 6, 3);
        bus.pwm_in = 1'b1;
        tick(4);
        n0 = n_strobe;
        check("en_pre_high", last_hi, 4);
        bus.en = 1'b0;
        tick(5);
        bus.en     = 1'b1;
        bus.pwm_in = 1'b0;
        tick(3);
        wave(2, 5, 1);
        tick(1);
        check("en_no_strobe",   n_strobe - n0,  0);
        check("en_hold_high",   bus.high_cnt,   4);
        check("en_hold_period", bus.period_cnt, 10);
        wave(2, 5, 2);
        tick(4);
        check("en_resume_count",  n_strobe - n0, 2);
        check("en_resume_high",   last_hi,       2);
        check("en_resume_period", last_per,      7);

        // stuck high -> timeout after MAXC cycles
        bus.en = 1'b0;
        tick(2);
        bus.en = 1'b1;
        tick(3);
        n0 = n_strobe;
        bus.pwm_in = 1'b1;
        tick(200);
        check("to_not_yet", bus.timeout, 0);
        tick(80);
        check("to_set",       bus.timeout,     1);
        check("to_stuck",     bus.stuck_level, 1);
        check("to_no_strobe", n_strobe - n0,   0);
        wave(2, 2, 3);
        tick(4);
        check("to_recover_count",   n_strobe - n0, 1);
        check("to_recover_high",    last_hi,       2);
        check("to_recover_period",  last_per,      4);
        check("to_recover_cleared", bus.timeout,   0);

        // rst pulsed during high phase
        wave(3, 7, 3);
        bus.pwm_in = 1'b1;
        tick(2);
        rst        = 1'b1;
        bus.pwm_in = 1'b0;
        tick(1);
        check("mid_rst_high",    bus.high_cnt,    0);
        check("mid_rst_period",  bus.period_cnt,  0);
        check("mid_rst_valid",   bus.meas_valid,  0);
        check("mid_rst_timeout", bus.timeout,     0);
        check("mid_rst_stuck",   bus.stuck_level, 0);
        rst = 1'b0;
        n0  = n_strobe;
        tick(7);
        wave(3, 7, 3);
        tick(4);
        check("post_rst_count",  n_strobe - n0, 2);
        check("post_rst_high",   last_hi,       3);
        check("post_rst_period", last_per,      10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
